// File: rtl/alu_share_ctrl.sv
// Round-robin controller that time-shares one registered ALU between two requesters.
// Optional macro DIVZERO_TRAP_EN answers div/mod by zero directly without using the ALU.
module alu_share_ctrl #(
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned DW      = 13
) (
   input  logic          aclk,
   input  logic          rst,
   // requester 0
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [DW-1:0] req0_x,
   input  logic [DW-1:0] req0_y,
   input  logic [2:0]    req0_op,
   // requester 1
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [DW-1:0] req1_x,
   input  logic [DW-1:0] req1_y,
   input  logic [2:0]    req1_op,
   // response channel
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [DW-1:0] rsp_result,
   output logic          rsp_zero,
   output logic          rsp_err,
   // ALU interface
   output logic [DW-1:0] alu_x,
   output logic [DW-1:0] alu_y,
   output logic [2:0]    alu_op,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_status
);

   localparam logic [2:0] OpDiv   = 3'b011;
   localparam logic [2:0] OpMod   = 3'b100;
   localparam logic [2:0] LatInit = 3'(ALU_LAT);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          last_grant_q, last_grant_d;
   logic [DW-1:0] alu_x_q, alu_x_d;
   logic [DW-1:0] alu_y_q, alu_y_d;
   logic [2:0]    alu_op_q, alu_op_d;
   logic          rsp_id_q, rsp_id_d;
   logic [DW-1:0] rsp_result_q, rsp_result_d;
   logic          rsp_zero_q, rsp_zero_d;
   logic          rsp_err_q, rsp_err_d;

   logic          any_valid;
   logic          grant;
   logic [DW-1:0] sel_x;
   logic [DW-1:0] sel_y;
   logic [2:0]    sel_op;
   logic          trap;

   // Arbitration: on contention the requester that did not win last time is chosen.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else begin
         grant = req1_valid;
      end
      sel_x  = grant ? req1_x  : req0_x;
      sel_y  = grant ? req1_y  : req0_y;
      sel_op = grant ? req1_op : req0_op;
   end

`ifdef DIVZERO_TRAP_EN
   assign trap = ((sel_op == OpDiv) || (sel_op == OpMod)) && (sel_y == '0);
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      alu_x_d      = alu_x_q;
      alu_y_d      = alu_y_q;
      alu_op_d     = alu_op_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;

      unique case (state_q)
         StIdle: begin
            req0_ready = req0_valid & ~grant;
            req1_ready = req1_valid & grant;
            if (any_valid) begin
               last_grant_d = grant;
               rsp_id_d     = grant;
               if (trap) begin
                  // Trapped ops never touch the ALU bus.
                  rsp_result_d = '0;
                  rsp_zero_d   = 1'b1;
                  rsp_err_d    = 1'b1;
                  state_d      = StResp;
               end else begin
                  alu_x_d  = sel_x;
                  alu_y_d  = sel_y;
                  alu_op_d = sel_op;
                  cnt_d    = LatInit;
                  state_d  = StWait;
               end
            end
         end
         StWait: begin
            if (cnt_q == 3'd0) begin
               rsp_result_d = alu_result;
               rsp_zero_d   = alu_status;
               rsp_err_d    = 1'b0;
               state_d      = StResp;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= 3'd0;
         last_grant_q <= 1'b1;
         alu_x_q      <= '0;
         alu_y_q      <= '0;
         alu_op_q     <= 3'b000;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         alu_x_q      <= alu_x_d;
         alu_y_q      <= alu_y_d;
         alu_op_q     <= alu_op_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp_valid  = (state_q == StResp);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign alu_x      = alu_x_q;
   assign alu_y      = alu_y_q;
   assign alu_op     = alu_op_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model; two instances cover ALU_LAT=1 and ALU_LAT=3.
module tb_alu_share_ctrl;

   localparam int unsigned DW    = 13;
   localparam int unsigned LAT_A = 1;
   localparam int unsigned LAT_B = 3;

   logic aclk = 1'b0;
   logic rst  = 1'b1;
   always #5 aclk = ~aclk;

   // instance A signals
   logic          req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
   logic [DW-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
   logic [2:0]    req0_op = '0, req1_op = '0;
   logic          req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err, alu_status;
   logic [DW-1:0] rsp_result, alu_x, alu_y, alu_result;
   logic [2:0]    alu_op;

   // instance B signals
   logic          b_req0_valid = 1'b0, b_req1_valid = 1'b0, b_rsp_ready = 1'b0;
   logic [DW-1:0] b_req0_x = '0, b_req0_y = '0, b_req1_x = '0, b_req1_y = '0;
   logic [2:0]    b_req0_op = '0, b_req1_op = '0;
   logic          b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_rsp_zero, b_rsp_err;
   logic          b_alu_status;
   logic [DW-1:0] b_rsp_result, b_alu_x, b_alu_y, b_alu_result;
   logic [2:0]    b_alu_op;

   function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic [2:0] op);
      case (op)
         3'd0:    return x;
         3'd1:    return x + y;
         3'd2:    return x - y;
         3'd3:    return (y == '0) ? '1 : x / y;
         3'd4:    return (y == '0) ? x : x % y;
         3'd5:    return (x > y) ? DW'(1) : '0;
         3'd6:    return x >> 1;
         default: return x << 1;
      endcase
   endfunction

   // External ALU models: registered pipelines of the configured depth.
   logic [DW-1:0] a_pipe;
   logic [DW-1:0] b_pipe [LAT_B];
   always @(posedge aclk) begin
      a_pipe    <= alu_fn(alu_x, alu_y, alu_op);
      b_pipe[0] <= alu_fn(b_alu_x, b_alu_y, b_alu_op);
      for (int i = 1; i < int'(LAT_B); i++) b_pipe[i] <= b_pipe[i-1];
   end
   assign alu_result   = a_pipe;
   assign alu_status   = (a_pipe == '0);
   assign b_alu_result = b_pipe[LAT_B-1];
   assign b_alu_status = (b_alu_result == '0);

   alu_share_ctrl #(.ALU_LAT(LAT_A), .DW(DW)) u_dut (
      .aclk(aclk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
      .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
      .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_result(alu_result),
      .alu_status(alu_status)
   );

   alu_share_ctrl #(.ALU_LAT(LAT_B), .DW(DW)) u_dut3 (
      .aclk(aclk), .rst(rst),
      .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_x(b_req0_x),
      .req0_y(b_req0_y), .req0_op(b_req0_op),
      .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_x(b_req1_x),
      .req1_y(b_req1_y), .req1_op(b_req1_op),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
      .rsp_result(b_rsp_result), .rsp_zero(b_rsp_zero), .rsp_err(b_rsp_err),
      .alu_x(b_alu_x), .alu_y(b_alu_y), .alu_op(b_alu_op), .alu_result(b_alu_result),
      .alu_status(b_alu_status)
   );

   int total = 0;
   int bad   = 0;
   int cycle = 0;
   int t0;
   int n;

   // random-phase model state
   logic          pending, last, exp_valid, e0, e1, w, is_trap;
   logic          exp_id, exp_zero, exp_err;
   logic [DW-1:0] exp_res, sx, sy;
   logic [2:0]    sop;
   int            resp_at;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_start();
      @(posedge aclk);
      #1;
      cycle++;
   endtask

   task automatic wait_rsp(input int start, input int exp_lat, input string tag);
      int k = 0;
      while (rsp_valid !== 1'b1 && k < 20) begin
         cyc_start();
         #1;
         k++;
      end
      check({tag, "_valid"}, 32'(rsp_valid), 1);
      check({tag, "_lat"}, cycle - start, exp_lat);
   endtask

   initial begin
      // reset values
      cyc_start();
      cyc_start();
      #1;
      check("rst_valid", 32'(rsp_valid), 0);
      check("rst_id", 32'(rsp_id), 0);
      check("rst_err", 32'(rsp_err), 0);
      check("rst_zero", 32'(rsp_zero), 0);
      check("rst_result", 32'(rsp_result), 0);
      check("rst_alu_x", 32'(alu_x), 0);
      check("rst_alu_y", 32'(alu_y), 0);
      check("rst_alu_op", 32'(alu_op), 0);
      check("rst_rdy0", 32'(req0_ready), 0);
      check("rst_b_valid", 32'(b_rsp_valid), 0);
      rst = 1'b0;

      // add 5+7 on requester 0
      cyc_start();
      req0_valid = 1; req0_op = 3'd1; req0_x = 5; req0_y = 7; rsp_ready = 1;
      #1;
      check("add_rdy0", 32'(req0_ready), 1);
      check("add_rdy1", 32'(req1_ready), 0);
      t0 = cycle;
      cyc_start(); req0_valid = 0; #1;
      wait_rsp(t0, 3, "add");
      check("add_id", 32'(rsp_id), 0);
      check("add_res", 32'(rsp_result), 12);
      check("add_zero", 32'(rsp_zero), 0);
      check("add_err", 32'(rsp_err), 0);
      cyc_start(); #1;
      check("add_done", 32'(rsp_valid), 0);

      // both valid after reset: requester 0 first, then requester 1
      cyc_start(); rst = 1; cyc_start(); rst = 0;
      req0_valid = 1; req0_op = 3'd2; req0_x = 9; req0_y = 9;
      req1_valid = 1; req1_op = 3'd6; req1_x = 8; req1_y = 0;
      #1;
      check("arb_rdy0", 32'(req0_ready), 1);
      check("arb_rdy1", 32'(req1_ready), 0);
      t0 = cycle;
      cyc_start(); req0_valid = 0; #1;
      check("arb_wait_rdy1", 32'(req1_ready), 0);
      wait_rsp(t0, 3, "arb0");
      check("arb0_res", 32'(rsp_result), 0);
      check("arb0_zero", 32'(rsp_zero), 1);
      check("arb0_id", 32'(rsp_id), 0);
      cyc_start(); #1;
      check("arb1_rdy1", 32'(req1_ready), 1);
      t0 = cycle;
      cyc_start(); req1_valid = 0; #1;
      wait_rsp(t0, 3, "arb1");
      check("arb1_res", 32'(rsp_result), 4);
      check("arb1_id", 32'(rsp_id), 1);
      check("arb1_zero", 32'(rsp_zero), 0);

      // back-pressure on the response channel
      cyc_start();
      rsp_ready = 0;
      req1_valid = 1; req1_op = 3'd7; req1_x = 3; req1_y = 0;
      #1;
      check("bp_rdy1", 32'(req1_ready), 1);
      t0 = cycle;
      cyc_start(); req1_valid = 0; #1;
      wait_rsp(t0, 3, "bp");
      req0_valid = 1; req0_op = 3'd0; req0_x = 13'h1fff; req0_y = 2;
      req1_valid = 1;
      for (int i = 0; i < 5; i++) begin
         cyc_start(); #1;
         check("bp_valid", 32'(rsp_valid), 1);
         check("bp_res", 32'(rsp_result), 6);
         check("bp_id", 32'(rsp_id), 1);
         check("bp_rdy0", 32'(req0_ready), 0);
         check("bp_rdy1", 32'(req1_ready), 0);
      end
      cyc_start(); rsp_ready = 1; #1;
      check("bp_hs_valid", 32'(rsp_valid), 1);
      cyc_start(); #1;
      check("bp_idle_valid", 32'(rsp_valid), 0);
      check("bp_idle_rdy0", 32'(req0_ready), 1);
      check("bp_idle_rdy1", 32'(req1_ready), 0);
      t0 = cycle;
      cyc_start(); req0_valid = 0; req1_valid = 0; #1;
      wait_rsp(t0, 3, "pass");
      check("pass_res", 32'(rsp_result), 32'h1fff);
      check("pass_id", 32'(rsp_id), 0);

      // divide by zero
      cyc_start();
      req0_valid = 1; req0_op = 3'd3; req0_x = 100; req0_y = 0;
      #1;
      check("dz_rdy0", 32'(req0_ready), 1);
      t0 = cycle;
      cyc_start(); req0_valid = 0; #1;
`ifdef DIVZERO_TRAP_EN
      wait_rsp(t0, 1, "dz");
      check("dz_err", 32'(rsp_err), 1);
      check("dz_res", 32'(rsp_result), 0);
      check("dz_zero", 32'(rsp_zero), 1);
      check("dz_alu_op", 32'(alu_op), 0);
`else
      wait_rsp(t0, 3, "dz");
      check("dz_err", 32'(rsp_err), 0);
      check("dz_res", 32'(rsp_result), 32'h1fff);
      check("dz_zero", 32'(rsp_zero), 0);
      check("dz_alu_op", 32'(alu_op), 3);
`endif

      // reset while waiting on the ALU
      cyc_start();
      req0_valid = 1; req0_op = 3'd1; req0_x = 20; req0_y = 22;
      #1;
      check("rw_rdy0", 32'(req0_ready), 1);
      cyc_start(); req0_valid = 0; rst = 1; #1;
      check("rw_wait_valid", 32'(rsp_valid), 0);
      cyc_start(); rst = 0; #1;
      check("rw_valid", 32'(rsp_valid), 0);
      check("rw_alu_op", 32'(alu_op), 0);
      check("rw_alu_x", 32'(alu_x), 0);
      for (int i = 0; i < 4; i++) begin
         cyc_start(); #1;
         check("rw_no_rsp", 32'(rsp_valid), 0);
      end
      cyc_start();
      req0_valid = 1; req1_valid = 1; req1_op = 3'd5; req1_x = 4; req1_y = 1;
      #1;
      check("rw_rdy0", 32'(req0_ready), 1);
      check("rw_rdy1", 32'(req1_ready), 0);
      t0 = cycle;
      cyc_start(); req0_valid = 0; req1_valid = 0; #1;
      wait_rsp(t0, 3, "rw");
      check("rw_res", 32'(rsp_result), 42);
      check("rw_id", 32'(rsp_id), 0);

      // ALU_LAT=3 instance: 17 mod 5 from requester 1
      cyc_start();
      b_req1_valid = 1; b_req1_op = 3'd4; b_req1_x = 17; b_req1_y = 5; b_rsp_ready = 1;
      #1;
      check("l3_rdy1", 32'(b_req1_ready), 1);
      check("l3_rdy0", 32'(b_req0_ready), 0);
      t0 = cycle;
      cyc_start(); b_req1_valid = 0; #1;
      n = 0;
      while (b_rsp_valid !== 1'b1 && n < 20) begin
         cyc_start(); #1; n++;
      end
      check("l3_valid", 32'(b_rsp_valid), 1);
      check("l3_lat", cycle - t0, 5);
      check("l3_res", 32'(b_rsp_result), 2);
      check("l3_id", 32'(b_rsp_id), 1);
      check("l3_zero", 32'(b_rsp_zero), 0);

      // randomized traffic against a transaction-level model
      cyc_start(); rst = 1; cyc_start(); rst = 0;
      pending = 1'b0; last = 1'b1; resp_at = 0;
      exp_id = 0; exp_res = '0; exp_zero = 0; exp_err = 0;
      for (int k = 0; k < 400; k++) begin
         if (k != 0) cyc_start();
         req0_valid = ($urandom_range(0, 1) == 1);
         req1_valid = ($urandom_range(0, 1) == 1);
         req0_op = 3'($urandom);
         req1_op = 3'($urandom);
         req0_x = DW'($urandom);
         req1_x = DW'($urandom);
         req0_y = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
         req1_y = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_valid = pending && (cycle >= resp_at);
         check("rnd_valid", 32'(rsp_valid), 32'(exp_valid));
         if (exp_valid) begin
            check("rnd_id", 32'(rsp_id), 32'(exp_id));
            check("rnd_res", 32'(rsp_result), 32'(exp_res));
            check("rnd_zero", 32'(rsp_zero), 32'(exp_zero));
            check("rnd_err", 32'(rsp_err), 32'(exp_err));
         end
         if (pending) begin
            e0 = 1'b0; e1 = 1'b0;
         end else if (req0_valid && req1_valid) begin
            e1 = (last == 1'b0); e0 = ~e1;
         end else begin
            e0 = req0_valid; e1 = req1_valid;
         end
         check("rnd_rdy0", 32'(req0_ready), 32'(e0));
         check("rnd_rdy1", 32'(req1_ready), 32'(e1));
         if (!pending && (req0_valid || req1_valid)) begin
            w   = e1;
            sx  = w ? req1_x : req0_x;
            sy  = w ? req1_y : req0_y;
            sop = w ? req1_op : req0_op;
`ifdef DIVZERO_TRAP_EN
            is_trap = ((sop == 3'd3) || (sop == 3'd4)) && (sy == '0);
`else
            is_trap = 1'b0;
`endif
            exp_id = w;
            last   = w;
            pending = 1'b1;
            if (is_trap) begin
               exp_res = '0; exp_zero = 1'b1; exp_err = 1'b1;
               resp_at = cycle + 1;
            end else begin
               exp_res  = alu_fn(sx, sy, sop);
               exp_zero = (exp_res == '0);
               exp_err  = 1'b0;
               resp_at  = cycle + int'(LAT_A) + 2;
            end
         end else if (exp_valid && rsp_ready) begin
            pending = 1'b0;
         end
      end
      req0_valid = 0; req1_valid = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Controller that time-shares one 13-bit registered ALU between two requesters. Opcode set: pass, add, sub, div, mod, gt, shr1, shl1.
- Arbitrates round-robin, captures operands, and drives the ALU input bus.
- Waits out the ALU latency, then returns the tagged result over a valid/ready response channel.
- Sits between the two command sources and the ALU instance; the ALU itself is external.

Parameters:
- ALU_LAT, 1, clock edges from stable ALU inputs to a valid alu_result/alu_status (range 1..7).
- DW, 13, operand/result width.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_x  in  DW  operand x.
- req0_y  in  DW  operand y.
- req0_op  in  3  opcode.
- req1_valid, req1_ready, req1_x, req1_y, req1_op: same as requester 0.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  DW  ALU result.
- rsp_zero  out  1  captured alu_status (result == 0).
- rsp_err  out  1  divide-by-zero trap flag.
- alu_x  out  DW  registered ALU operand x.
- alu_y  out  DW  registered ALU operand y.
- alu_op  out  3  registered ALU opcode.
- alu_result  in  DW  ALU result.
- alu_status  in  1  ALU zero flag.

Behaviour:
- Reset values (sync, rst=1): state IDLE; alu_x, alu_y = 0; alu_op = 3'b000; rsp_valid, rsp_id, rsp_err, rsp_zero = 0; rsp_result = 0; last_grant = 1 (requester 0 wins first); wait counter = 0.
- States: IDLE, WAIT, RESP.
- IDLE, requester readiness:
  - reqN_ready is combinational, high only in IDLE for the granted requester.
  - Both valid: grant the requester that is not last_grant.
  - Only one valid: grant it.
  - Neither valid: both ready = 0.
- IDLE, accept (valid && ready in cycle T):
  - Load alu_x/alu_y/alu_op from the winner; set rsp_id = winner and last_grant = winner.
  - Load counter = ALU_LAT; go to WAIT.
- WAIT:
  - ALU inputs are held stable.
  - Counter decrements each cycle.
  - On the edge where counter == 0: capture rsp_result = alu_result and rsp_zero = alu_status; set rsp_err = 0; go to RESP.
  - WAIT lasts ALU_LAT+1 cycles.
- RESP:
  - rsp_valid = 1; all rsp_* held stable until rsp_ready = 1.
  - On handshake: rsp_valid = 0 on the next edge; go to IDLE.
  - No new command is accepted until the cycle after the handshake (ready = 0 in WAIT and RESP).
- Latency: accept at T, rsp_valid high from T+ALU_LAT+2 (T+3 at default).
- Minimum issue interval: ALU_LAT+3 cycles with rsp_ready held high.
- Response data changes only on the WAIT-to-RESP edge; rsp_result is exactly DW bits, no extension.
- Requester dropping valid while not granted: no effect, nothing latched.
- rst mid-operation (WAIT or RESP): in-flight op discarded without a response; every output returns to its reset value on the next edge.
- rst has priority over every other event.
- The ALU's default/undefined outputs are never sampled outside the capture edge.

Optional Feature:
Macro DIVZERO_TRAP_EN.
- Defined: at accept, if op is 3'b011 or 3'b100 and y == 0:
  - alu_x/alu_y/alu_op are NOT updated and the ALU is not used.
  - Go straight to RESP on the next edge with rsp_result = 0, rsp_zero = 1, rsp_err = 1.
  - rsp_valid goes high at T+1.
- Undefined: no check; the op is issued normally, rsp_err is constant 0, and rsp_result is whatever the ALU returns.

Test Plan:
- Reset, then req0 op=001 x=5 y=7, rsp_ready=1 -> req0_ready high at T; rsp_valid at T+3; rsp_id=0, rsp_result=12, rsp_zero=0.
- req0 (op=010 x=9 y=9) and req1 (op=110 x=8) both valid from reset -> req0 served first: result=0, zero=1. Then req1: result=4, id=1, accepted the cycle after req0's response handshake.
- req1 op=111 x=3, rsp_ready held low 5 cycles -> rsp_valid and result=6 stable throughout; req0_ready and req1_ready = 0 during the stall; IDLE returns one cycle after rsp_ready rises.
- req0 op=011 x=100 y=0 -> with DIVZERO_TRAP_EN: rsp_valid at T+1, err=1, result=0, zero=1, alu_op unchanged. Without the macro: response at T+3, err=0.
- Assert rst for 1 cycle while in WAIT -> next cycle rsp_valid=0, alu_op=000; no response emitted; with both requesters then valid, req0 is granted first.
- ALU_LAT=3, req1 op=100 x=17 y=5 -> rsp_valid at T+5, result=2, id=1.
